// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns engine: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock in place, and returns it over valid/ready.
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant multiplies 9, b, d, e assembled from the x2/x4/x8 chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    inv_mix_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                   m9[0] ^ me[1] ^ mb[2] ^ md[3],
                   md[0] ^ m9[1] ^ me[2] ^ mb[3],
                   mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  state_t       state_r, state_nxt_s;
  logic [127:0] data_r, data_nxt_s, out_data_r;
  logic [1:0]   cnt_r, col_idx_s;
  logic         last_s;
  logic         out_valid_r, busy_r, in_ready_r;

  assign last_s    = (cnt_r == CNT_LAST);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;
  assign in_ready  = in_ready_r;

  // Column datapath: column k of the group sits at bits {~idx, 5'h1f} downward.
  always_comb begin
    data_nxt_s = data_r;
    col_idx_s  = cnt_r;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      col_idx_s = cnt_r + 2'(k);
      data_nxt_s[{~col_idx_s, 5'h1f} -: 32] = inv_mix_col(data_r[{~col_idx_s, 5'h1f} -: 32]);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = BUSY;
        else          state_nxt_s = IDLE;
      end
      BUSY: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = BUSY;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, working register, column counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      data_r      <= 128'h0;
      cnt_r       <= 2'd0;
      out_data_r  <= 128'h0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s == DONE);
      busy_r      <= (state_nxt_s != IDLE);
      in_ready_r  <= (state_nxt_s == IDLE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            data_r <= in_data;
            cnt_r  <= 2'd0;
          end
        end
        BUSY: begin
          data_r <= data_nxt_s;
          if (last_s) begin
            cnt_r      <= 2'd0;
            out_data_r <= data_nxt_s;
          end else begin
            cnt_r <= cnt_r + CNT_STEP;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
- Sequential AES InvMixColumns engine for the decryption datapath; the inverse of the forward column-mixing stage.
- Accepts a full 128-bit AES state through a valid/ready handshake and transforms COLS_PER_CYCLE columns per clock in place.
- Returns the result through a second valid/ready handshake.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the iterative decrypt round.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per BUSY cycle. Legal values: 1, 2, 4. Any other value is a compile-time error.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream state valid
- in_ready  out  1  block can accept a state (high only in IDLE)
- in_data  in  128  input state; column c = in_data[127-32c -: 32]; row 0 is the MSB byte of each column
- out_valid  out  1  out_data holds a complete result
- out_ready  in  1  downstream accepts the result
- out_data  out  128  transformed state; same byte layout as in_data
- busy  out  1  high in BUSY or DONE

Behaviour:
- Reset (async assert on rst_n low, sync release):
  - state = IDLE, state register = 0, column counter = 0.
  - out_valid = 0, out_data = 0, busy = 0, in_ready = 1.
- Column math, per column (a0..a3, row 0 first), all in GF(2^8) with polynomial 0x11b:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
  - Multiplication is built from xtime chains (x2, x4, x8). No lookup tables.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_data into the state register, clear the column counter, go to BUSY.
  - in_data is ignored when in_valid = 0.
- BUSY:
  - in_ready = 0.
  - Each cycle, replace columns [cnt .. cnt+COLS_PER_CYCLE-1] with their transform and advance cnt by COLS_PER_CYCLE.
  - On the cycle that processes column 3, go to DONE and set out_valid = 1 at that same edge.
  - Latency: out_valid rises 4/COLS_PER_CYCLE edges after the accepting edge (4, 2 or 1).
  - The counter wraps to 0 on leaving BUSY.
- DONE:
  - out_valid = 1; out_data equals the state register and is held stable.
  - out_valid and out_data must not change until out_ready is sampled high.
  - On out_valid & out_ready: out_valid = 0, go to IDLE. out_data keeps its last value.
  - in_ready rises only on the following cycle; no same-cycle accept-while-emit.
- Simultaneous events:
  - in_valid while BUSY or DONE: ignored. Upstream must hold the state until in_ready.
  - out_ready while not DONE: no effect.
- Reset mid-operation: any state returns to IDLE immediately. A partially transformed state is discarded and never presented.
- No X propagation: all registers are reset, and the state register updates only in IDLE-accept or BUSY.

Test Plan:
1. Column vectors, COLS_PER_CYCLE=1: in_data = 8e4da1bc_9fdc589d_4d7ebdf8_d5d5d7d6 -> out_data = db135345_f20a225c_2d26314c_d4d4d4d5. out_valid rises exactly 4 edges after the accept.
2. Fixed points: in_data = c6c6c6c6_01010101_00000000_ffffffff -> same value out. Repeat with COLS_PER_CYCLE=2 and 4; latency must be 2 and 1 respectively.
3. Backpressure: hold out_ready = 0 for 10 cycles in DONE. out_data and out_valid stay constant, in_ready stays 0, and a new in_valid pulse is not accepted. Releasing out_ready completes exactly one transfer.
4. Back-to-back: keep in_valid high with two states and out_ready = 1. Each result is correct, and the second accept occurs one cycle after the first output handshake.
5. Reset mid-BUSY: assert rst_n low during cycle 2 of BUSY. All outputs return to reset values asynchronously, out_valid never pulses, and the next accepted state (vector 1) produces the correct result.
6. Round-trip: 1000 random states through the forward column mix, then this block. The output equals the original state every time.
